if_stage_pipe: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the pipelined KGP-RISC core.
- Owns the PC, drives the instruction-memory address and latches the fetched instruction into IF/ID.
- Honours the pc_write and if_id_write hold controls from the load-use hazard unit and the branch-redirect flush from EX.
- Keeps saturating stall and flush counters for performance debug.

---
 rtl/if_stage_pipe.sv | 79 +++++++
 tb/tb_if_stage_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage and IF/ID pipeline register for the pipelined KGP-RISC core.
// Owns the PC, presents it to instruction memory and captures the fetched word into IF/ID.
module if_stage_pipe #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             if_id_write,
    input  logic             flush,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc_plus4,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Hold/flush semantics: flush redirects the PC and squashes IF/ID regardless
    // of the write enables; otherwise pc_write advances the PC and if_id_write
    // loads IF/ID, each independently; a deasserted enable holds its register.

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0] pc;
    logic [31:0] pc_plus4;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (flush) begin
            pc <= branch_target;
        end else if (pc_write) begin
            pc <= pc_plus4;
        end
    end

    // The instruction behind a taken branch is on the wrong path, so flush beats if_id_write.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else if (if_id_write) begin
            if_id_instr    <= imem_rdata;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
        end
    end

    // A cycle with flush counts only as a flush, never as a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (flush) begin
                if (flush_count != CNT_MAX) begin
                    flush_count <= flush_count + 1'b1;
                end
            end else if (!pc_write) begin
                if (stall_count != CNT_MAX) begin
                    stall_count <= stall_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage_pipe.sv
// Bench for if_stage_pipe: directed scenarios followed by random control traffic,
// every cycle compared against a fetch-stage reference model.
module tb_if_stage_pipe;

    localparam int          CNT_W     = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          CNT_SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pc_write = 1'b0;
    logic             if_id_write = 1'b0;
    logic             flush = 1'b0;
    logic [31:0]      branch_target = 32'd0;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      if_id_pc;
    logic [31:0]      if_id_pc_plus4;
    logic [31:0]      if_id_instr;
    logic             if_id_valid;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    longint m_pc;
    longint m_id_pc;
    longint m_id_pc4;
    longint m_id_instr;
    int     m_valid;
    int     m_stalls;
    int     m_flushes;

    if_stage_pipe #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    always #5 clk = ~clk;

    // instruction memory: word at address a reads as 0x1000_0000 + a
    assign imem_rdata = 32'h1000_0000 + imem_addr;

    function automatic longint mem_word(input longint addr);
        return (64'h1000_0000 + addr) % 64'h1_0000_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_id_pc   = 0;
        m_id_pc4  = 0;
        m_id_instr = NOP_INSTR;
        m_valid   = 0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    // One clock of the fetch stage, from the inputs in force at the edge.
    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (flush) begin
            if (m_flushes < CNT_SAT) m_flushes = m_flushes + 1;
            m_pc       = branch_target;
            m_id_pc    = 0;
            m_id_pc4   = 0;
            m_id_instr = NOP_INSTR;
            m_valid    = 0;
        end else begin
            if (!pc_write && m_stalls < CNT_SAT) m_stalls = m_stalls + 1;
            if (if_id_write) begin
                m_id_pc    = m_pc;
                m_id_pc4   = (m_pc + 4) % 64'h1_0000_0000;
                m_id_instr = mem_word(m_pc);
                m_valid    = 1;
            end
            if (pc_write) m_pc = (m_pc + 4) % 64'h1_0000_0000;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".imem_addr"}, imem_addr, 32'(m_pc));
        check({tag, ".if_id_pc"}, if_id_pc, 32'(m_id_pc));
        check({tag, ".if_id_pc_plus4"}, if_id_pc_plus4, 32'(m_id_pc4));
        check({tag, ".if_id_instr"}, if_id_instr, 32'(m_id_instr));
        check({tag, ".if_id_valid"}, {31'd0, if_id_valid}, 32'(m_valid));
        check({tag, ".stall_count"}, {{(32-CNT_W){1'b0}}, stall_count}, 32'(m_stalls));
        check({tag, ".flush_count"}, {{(32-CNT_W){1'b0}}, flush_count}, 32'(m_flushes));
    endtask

    task automatic drive(input logic r, input logic pw, input logic iw, input logic fl,
                         input logic [31:0] tgt);
        rst           = r;
        pc_write      = pw;
        if_id_write   = iw;
        flush         = fl;
        branch_target = tgt;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();

        // reset for two cycles
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step("reset0");
        step("reset1");
        check("reset.pc_const", imem_addr, 32'h0);
        check("reset.valid_const", {31'd0, if_id_valid}, 32'd0);

        // sequential fetch
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        step("run1");
        check("run1.pc_const", imem_addr, 32'h4);
        check("run1.valid_rise", {31'd0, if_id_valid}, 32'd1);
        check("run1.instr_const", if_id_instr, 32'h1000_0000);
        step("run2");
        check("run2.pc_const", imem_addr, 32'h8);
        check("run2.id_pc_const", if_id_pc, 32'h4);

        // load-use stall at pc=8
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step("stall");
        check("stall.pc_held", imem_addr, 32'h8);
        check("stall.id_pc_held", if_id_pc, 32'h4);
        check("stall.count", {{(32-CNT_W){1'b0}}, stall_count}, 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        step("resume");
        check("resume.pc_const", imem_addr, 32'hC);
        check("resume.instr_const", if_id_instr, 32'h1000_0008);
        step("run3");

        // flush at pc=0x10
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
        step("flush");
        check("flush.pc_const", imem_addr, 32'h40);
        check("flush.instr_nop", if_id_instr, NOP_INSTR);
        check("flush.count", {{(32-CNT_W){1'b0}}, flush_count}, 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        step("post_flush");
        check("post_flush.id_pc", if_id_pc, 32'h40);

        // flush during stall
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
        step("flush_stall");
        check("flush_stall.pc_const", imem_addr, 32'h80);
        check("flush_stall.stalls_kept", {{(32-CNT_W){1'b0}}, stall_count}, 32'd1);

        // wrap from 0xFFFF_FFFC
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step("to_top");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        step("wrap");
        check("wrap.pc_const", imem_addr, 32'h0);
        check("wrap.plus4_const", if_id_pc_plus4, 32'h0);

        // stall counter saturation
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 20; i++) step("sat");
        check("sat.const", {{(32-CNT_W){1'b0}}, stall_count}, 32'hF);

        // reset during an active stall
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step("mid_reset");
        check("mid_reset.stalls", {{(32-CNT_W){1'b0}}, stall_count}, 32'd0);
        check("mid_reset.flushes", {{(32-CNT_W){1'b0}}, flush_count}, 32'd0);

        // random control traffic
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 12,
                  $urandom());
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
